// File: rtl/cache_types_pkg.sv
// ============================================================================
// Module   : cache_types_pkg
// Purpose  : Shared widths and enumerations for the L1-to-memory line path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_types_pkg;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

`default_nettype wire

// File: rtl/cache_arbiter_reg.sv
// ============================================================================
// Module   : cache_arbiter_reg
// Purpose  : Load-enabled register with asynchronous active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_arbiter_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/cache_arbiter.sv
// ============================================================================
// Module   : cache_arbiter
// Purpose  : Fair 2:1 arbiter (I-cache / D-cache) onto one 256-bit line port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_arbiter
    import cache_types_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              imem_read,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic [LINE_W-1:0] imem_rdata,
    output logic              imem_resp,
    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [LINE_W-1:0] dmem_wdata,
    output logic [LINE_W-1:0] dmem_rdata,
    output logic              dmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    grant_t            r_last_grant;
    logic              w_req_i;
    logic              w_req_d;
    logic              w_load;
    logic              w_serving;
    logic [ADDR_W-1:0] w_addr_next;
    logic              w_op_next;
    logic              w_op;

    assign w_req_i   = imem_read;
    assign w_req_d   = dmem_read | dmem_write;
    assign w_serving = (r_state == SERVE_I) || (r_state == SERVE_D);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_D;
        end else begin
            r_state <= w_state_next;
            if (w_serving && mem_resp) begin
                r_last_grant <= (r_state == SERVE_I) ? GRANT_I : GRANT_D;
            end
        end
    end

    // Op bit: 1 = line write-back, 0 = line read. Write wins on the D side.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_addr_next  = imem_addr;
        w_op_next    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_i && (!w_req_d || (r_last_grant == GRANT_D))) begin
                    w_state_next = SERVE_I;
                    w_load       = 1'b1;
                end else if (w_req_d) begin
                    w_state_next = SERVE_D;
                    w_load       = 1'b1;
                    w_addr_next  = dmem_addr;
                    w_op_next    = dmem_write;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    cache_arbiter_reg #(.WIDTH(ADDR_W)) u_addr_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_d    (w_addr_next),
        .o_q    (mem_addr)
    );

    cache_arbiter_reg #(.WIDTH(LINE_W)) u_wdata_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_d    (dmem_wdata),
        .o_q    (mem_wdata)
    );

    cache_arbiter_reg #(.WIDTH(1)) u_op_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_d    (w_op_next),
        .o_q    (w_op)
    );

    assign mem_read   = w_serving & ~w_op;
    assign mem_write  = w_serving &  w_op;
    assign imem_resp  = (r_state == SERVE_I) & mem_resp;
    assign dmem_resp  = (r_state == SERVE_D) & mem_resp;
    assign imem_rdata = mem_rdata;
    assign dmem_rdata = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
// ============================================================================
// Module   : tb_cache_arbiter
// Purpose  : Self-checking bench: directed vector table, corner sequences,
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         imem_read;
    logic [31:0]  imem_addr;
    logic [255:0] imem_rdata;
    logic         imem_resp;
    logic         dmem_read;
    logic         dmem_write;
    logic [31:0]  dmem_addr;
    logic [255:0] dmem_wdata;
    logic [255:0] dmem_rdata;
    logic         dmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    cache_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_read  (imem_read),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] PAT_A5   = {32{8'hA5}};
    localparam logic [255:0] PAT_1234 = {16{16'h1234}};

    typedef struct {
        logic        ir, dr, dw, mr;
        logic [31:0] ia, da;
        logic        er, ew, eir, edr;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ir, dr, dw, mr, input logic [31:0] ia, da,
                                input logic er, ew, eir, edr, input logic [31:0] eaddr);
        vec_t v;
        v.ir = ir; v.dr = dr; v.dw = dw; v.mr = mr; v.ia = ia; v.da = da;
        v.er = er; v.ew = ew; v.eir = eir; v.edr = edr; v.eaddr = eaddr;
        return v;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic idle_inputs();
        imem_read = 1'b0; imem_addr = '0;
        dmem_read = 1'b0; dmem_write = 1'b0; dmem_addr = '0; dmem_wdata = '0;
        mem_rdata = '0;   mem_resp = 1'b0;
    endtask

    // Leaves the bench 1 time unit after a rising edge, the point where inputs are driven.
    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one outstanding line transaction, a dead cycle after
    // each completion, and ties going to the side that did not win last.
    int           m_side;      // 0 none, 1 I-side, 2 D-side
    bit           m_gap;
    bit           m_last_d;
    bit           m_wr;
    logic [31:0]  m_addr;
    logic [255:0] m_wdata;
    int           m_wait;
    int           m_dly;

    task automatic model_reset();
        m_side = 0; m_gap = 0; m_last_d = 1; m_wr = 0;
        m_addr = '0; m_wdata = '0; m_wait = 0; m_dly = 0;
    endtask

    task automatic model_clock();
        bit ri, rd;
        ri = imem_read;
        rd = dmem_read | dmem_write;
        if (m_gap) begin
            m_gap = 0;
        end else if (m_side != 0) begin
            if (mem_resp) begin
                m_last_d = (m_side == 2);
                m_side   = 0;
                m_gap    = 1;
            end else begin
                m_wait++;
            end
        end else if (ri || rd) begin
            if (ri && (!rd || m_last_d)) begin
                m_side = 1; m_addr = imem_addr; m_wr = 0;
            end else begin
                m_side = 2; m_addr = dmem_addr; m_wr = dmem_write;
            end
            m_wdata = dmem_wdata;
            m_wait  = 0;
            m_dly   = int'($urandom_range(0, 3));
        end
    endtask

    logic [31:0] grants[$];
    logic [31:0] exp_order[4];

    initial begin
        bit prev_act, act, gap_chk, i_seen, d_seen;
        int cnt;

        // ---------------- directed vector table ----------------
        tbl[0]  = mk(0,0,0,0, 32'h0,    32'h0,    0,0,0,0, 32'h0);
        tbl[1]  = mk(1,0,0,0, 32'h1000, 32'h0,    0,0,0,0, 32'h0);
        tbl[2]  = mk(1,0,0,0, 32'h1000, 32'h0,    1,0,0,0, 32'h1000);
        tbl[3]  = mk(1,0,0,0, 32'h1000, 32'h0,    1,0,0,0, 32'h1000);
        tbl[4]  = mk(1,0,0,0, 32'h1000, 32'h0,    1,0,0,0, 32'h1000);
        tbl[5]  = mk(1,0,0,1, 32'h1000, 32'h0,    1,0,1,0, 32'h1000);
        tbl[6]  = mk(0,0,0,0, 32'h0,    32'h0,    0,0,0,0, 32'h1000);
        tbl[7]  = mk(0,0,1,0, 32'h0,    32'h2000, 0,0,0,0, 32'h1000);
        tbl[8]  = mk(0,0,1,0, 32'h0,    32'h2000, 0,1,0,0, 32'h2000);
        tbl[9]  = mk(0,0,1,1, 32'h0,    32'h2000, 0,1,0,1, 32'h2000);
        tbl[10] = mk(0,0,0,0, 32'h0,    32'h0,    0,0,0,0, 32'h2000);
        tbl[11] = mk(0,0,0,1, 32'h0,    32'h0,    0,0,0,0, 32'h2000);
        tbl[12] = mk(0,1,1,0, 32'h0,    32'h3000, 0,0,0,0, 32'h2000);
        tbl[13] = mk(0,1,1,0, 32'h0,    32'h3000, 0,1,0,0, 32'h3000);
        tbl[14] = mk(0,1,1,1, 32'h0,    32'h3000, 0,1,0,1, 32'h3000);
        tbl[15] = mk(0,0,0,0, 32'h0,    32'h0,    0,0,0,0, 32'h3000);

        do_reset();
        check("reset_mem_wdata", mem_wdata, '0);
        for (int i = 0; i < 16; i++) begin
            imem_read = tbl[i].ir; imem_addr = tbl[i].ia;
            dmem_read = tbl[i].dr; dmem_write = tbl[i].dw; dmem_addr = tbl[i].da;
            mem_resp  = tbl[i].mr; mem_rdata = PAT_A5;
            #7;
            check($sformatf("tbl%0d_mem_read", i),  256'(mem_read),  256'(tbl[i].er));
            check($sformatf("tbl%0d_mem_write", i), 256'(mem_write), 256'(tbl[i].ew));
            check($sformatf("tbl%0d_imem_resp", i), 256'(imem_resp), 256'(tbl[i].eir));
            check($sformatf("tbl%0d_dmem_resp", i), 256'(dmem_resp), 256'(tbl[i].edr));
            check($sformatf("tbl%0d_mem_addr", i),  256'(mem_addr),  256'(tbl[i].eaddr));
            if (tbl[i].eir) check($sformatf("tbl%0d_imem_rdata", i), imem_rdata, PAT_A5);
            if (tbl[i].edr) check($sformatf("tbl%0d_dmem_rdata", i), dmem_rdata, PAT_A5);
            next_cycle();
        end

        // ---------------- write-back data held after grant ----------------
        do_reset();
        dmem_write = 1'b1; dmem_addr = 32'h2000; dmem_wdata = PAT_1234;
        next_cycle();
        dmem_wdata = ~PAT_1234;
        for (int i = 0; i < 2; i++) begin
            #7;
            check("wb_mem_write", 256'(mem_write), 256'(1'b1));
            check("wb_mem_read",  256'(mem_read),  256'(1'b0));
            check("wb_mem_wdata", mem_wdata, PAT_1234);
            next_cycle();
        end
        mem_resp = 1'b1;
        #7 check("wb_dmem_resp", 256'({imem_resp, dmem_resp}), 256'(2'b01));
        next_cycle();
        mem_resp = 1'b0; dmem_write = 1'b0;
        #7 check("wb_done_resp", 256'({imem_resp, dmem_resp, mem_write}), 256'(3'b000));
        next_cycle();

        // ---------------- reset while serving a write-back ----------------
        do_reset();
        dmem_write = 1'b1; dmem_addr = 32'h4000; dmem_wdata = PAT_1234;
        next_cycle();
        #3 check("rst_pre_write", 256'(mem_write), 256'(1'b1));
        mem_resp = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_out", 256'({mem_read, mem_write, imem_resp, dmem_resp}), 256'(4'b0000));
        check("rst_async_addr", 256'(mem_addr), 256'(32'h0));
        mem_resp = 1'b0; dmem_write = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        imem_read = 1'b1; imem_addr = 32'h5000;
        #7 check("rst_idle_after", 256'({mem_read, mem_write}), 256'(2'b00));
        next_cycle();
        #7;
        check("rst_regrant_read", 256'({mem_read, mem_write}), 256'(2'b10));
        check("rst_regrant_addr", 256'(mem_addr), 256'(32'h5000));
        next_cycle();

        // ---------------- both sides held: strict alternation ----------------
        do_reset();
        imem_read = 1'b1; imem_addr = 32'h100;
        dmem_read = 1'b1; dmem_addr = 32'h200;
        exp_order = '{32'h100, 32'h200, 32'h100, 32'h200};
        grants.delete();
        prev_act = 0; gap_chk = 0; cnt = 0;
        for (int c = 0; c < 20; c++) begin
            act = mem_read | mem_write;
            if (gap_chk) check("alt_done_gap", 256'(act), 256'(1'b0));
            if (act && !prev_act) begin
                grants.push_back(mem_addr);
                cnt = 0;
            end else if (act) begin
                cnt++;
            end
            mem_resp = act && (cnt == 1);
            #7;
            if (mem_resp)
                check("alt_resp_side", 256'({imem_resp, dmem_resp}),
                      256'((mem_addr == 32'h100) ? 2'b10 : 2'b01));
            gap_chk  = mem_resp;
            prev_act = act;
            next_cycle();
        end
        mem_resp = 1'b0;
        check("alt_grant_count", 256'(grants.size() >= 4), 256'(1'b1));
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size())
                check($sformatf("alt_grant%0d", i), 256'(grants[i]), 256'(exp_order[i]));
        end

        // ---------------- randomized traffic vs. reference model ----------------
        do_reset();
        model_reset();
        i_seen = 0; d_seen = 0;
        for (int c = 0; c < 1500; c++) begin
            int op;
            if (imem_read && (i_seen || $urandom_range(0, 49) == 0)) imem_read = 1'b0;
            else if (!imem_read && $urandom_range(0, 3) == 0) begin
                imem_read = 1'b1; imem_addr = $urandom();
            end
            if ((dmem_read || dmem_write) && (d_seen || $urandom_range(0, 49) == 0)) begin
                dmem_read = 1'b0; dmem_write = 1'b0;
            end else if (!(dmem_read || dmem_write) && $urandom_range(0, 3) == 0) begin
                op = int'($urandom_range(0, 2));
                dmem_read  = (op != 1);
                dmem_write = (op != 0);
                dmem_addr  = $urandom();
            end
            dmem_wdata = rand256();
            mem_rdata  = rand256();
            if (m_side != 0 && !m_gap) mem_resp = (m_wait >= m_dly);
            else                       mem_resp = ($urandom_range(0, 7) == 0);
            #7;
            check("rnd_mem_read",  256'(mem_read),  256'(m_side != 0 && !m_wr));
            check("rnd_mem_write", 256'(mem_write), 256'(m_side != 0 && m_wr));
            check("rnd_imem_resp", 256'(imem_resp), 256'(m_side == 1 && mem_resp));
            check("rnd_dmem_resp", 256'(dmem_resp), 256'(m_side == 2 && mem_resp));
            check("rnd_mem_addr",  256'(mem_addr),  256'(m_addr));
            check("rnd_imem_rdata", imem_rdata, mem_rdata);
            check("rnd_dmem_rdata", dmem_rdata, mem_rdata);
            if (m_side == 2 && m_wr) check("rnd_mem_wdata", mem_wdata, m_wdata);
            i_seen = (m_side == 1) && mem_resp;
            d_seen = (m_side == 2) && mem_resp;
            @(posedge clk);
            model_clock();
            #1;
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
